mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the processor's single-port unified instruction/data memory between two requesters: the instruction-fetch path and the load/store path.
- One transaction is in flight at a time.
- Per transaction: accept a request, issue it to memory, wait the fixed read latency, return a registered response to the owning requester.
- Sits between the processor datapath and the memory array inside riscv_processor.

Parameters:
ADDR_W, 32, byte-address width of both requesters
DATA_W, 32, data width (must be 32; wmask is 4 bits)
MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata (legal 1..3)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
if_req_valid  input  1  fetch request
if_req_ready  output  1  fetch request accepted this cycle
if_addr  input  ADDR_W  fetch byte address
if_rsp_valid  output  1  one-cycle fetch response pulse
if_rdata  output  DATA_W  fetched word, valid with if_rsp_valid
d_req_valid  input  1  load/store request
d_req_ready  output  1  load/store request accepted this cycle
d_addr  input  ADDR_W  load/store byte address
d_we  input  1  1=store, 0=load
d_wmask  input  4  byte-lane write enables, used only when d_we=1
d_wdata  input  DATA_W  store data
d_rsp_valid  output  1  one-cycle load/store response pulse (also acks stores)
d_rdata  output  DATA_W  load data; 0 for stores
mem_en  output  1  memory access strobe
mem_we  output  4  memory byte write enables
mem_addr  output  ADDR_W-2  word address (byte address bits [ADDR_W-1:2])
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
busy  output  1  high when state is not IDLE

Behaviour:
- Reset state: IDLE. mem_en, mem_we, mem_addr, mem_wdata, both rsp_valid, both rdata and busy are 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any request is valid, assert the winner's ready combinationally; the accept is valid&&ready. On accept, latch owner, address, we, wmask and wdata, then go to ISSUE. The loser's ready stays 0.
  - ISSUE (1 cycle): registered mem_en=1, mem_addr=latched addr[ADDR_W-1:2], mem_wdata=latched data. mem_we=latched wmask for stores, 4'b0000 for loads and fetches. Go to WAIT with the latency counter cleared.
  - WAIT (exactly MEM_LAT cycles): mem_en=0, mem_we=0. On the last WAIT cycle, capture mem_rdata into the owner's rdata register (0 for stores). Go to RESP.
  - RESP (1 cycle): owner's rsp_valid=1; the other requester's rsp_valid stays 0. Go to IDLE.
- Latency and throughput:
  - Accept in cycle T → mem_en in T+1 → rsp_valid in T+2+MEM_LAT.
  - Next accept no earlier than T+3+MEM_LAT.
- rdata holds its value until that requester's next response.
- Arbitration with both valid in IDLE: data wins (fixed priority); fetch waits.
- Address low bits [1:0] are ignored; no misalignment fault is raised.
- Requester rule: valid and payload are held stable until ready. A drop before accept is a protocol violation, flagged by a bench assertion; the arbiter does not depend on it.
- A request that becomes valid while busy is not accepted until IDLE.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. The in-flight transaction is discarded and no rsp_valid is produced.
- Counter width is clog2(MEM_LAT+1); wrap is impossible because it is cleared in ISSUE.

Optional Feature:
ARB_RR_EN
- Defined: round-robin between fetch and data on contention.
  - A last_grant flop updates on every accept; reset value is "fetch".
  - With both valid in IDLE, the requester not matching last_grant wins, so the first contention after reset goes to data.
  - A single valid requester always wins regardless of last_grant.
- Undefined: fixed data-over-fetch priority; no last_grant flop is synthesised.

Test Plan:
1. MEM_LAT=1, fetch only, if_addr=0x0000_0010 accepted at T, mem_rdata=0xDEADBEEF at T+2 → mem_en=1 and mem_addr=0x4 at T+1; if_rsp_valid=1 and if_rdata=0xDEADBEEF at T+3; d_rsp_valid stays 0.
2. Store d_addr=0x20, d_wmask=4'b0011, d_wdata=0x1234_5678 → mem_we=4'b0011, mem_addr=0x8 and mem_wdata=0x12345678 for one cycle only; d_rsp_valid pulses with d_rdata=0.
3. Both valid in the same IDLE cycle, fixed priority → d_req_ready=1, if_req_ready=0; data completes first, fetch accepted exactly 4 cycles later (MEM_LAT=1).
4. ARB_RR_EN defined, both held valid for 4 transactions → grant order data, fetch, data, fetch.
5. rst_n driven low during WAIT → outputs 0 asynchronously (before next clk edge); no rsp_valid after release; first request after reset completes normally.
6. MEM_LAT=3 load → rsp_valid exactly 5 cycles after accept; busy high for 5 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store requesters, one access at a time.
// Build option: define ARB_RR_EN for round-robin arbitration instead of fixed data-over-fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              own_data_q, own_data_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_rsp_q, if_rsp_d, d_rsp_q, d_rsp_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              idle, grant_data, accept;

  // Byte offsets are dropped: the memory is word addressed and no alignment fault exists.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  assign idle   = (state_q == StIdle);
  assign accept = idle & (d_req_valid | if_req_valid);

`ifdef ARB_RR_EN
  logic last_data_q; // 1: most recent accept went to the data side

  assign grant_data = d_req_valid & (~if_req_valid | ~last_data_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_data_q <= 1'b0;
    end else if (accept) begin
      last_data_q <= grant_data;
    end
  end
`else
  assign grant_data = d_req_valid;
`endif

  assign d_req_ready  = idle & grant_data;
  assign if_req_ready = idle & if_req_valid & ~grant_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_data_d  = own_data_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'b0000;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_rsp_d    = 1'b0;
    d_rsp_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StIssue;
          own_data_d = grant_data;
          we_d       = grant_data & d_we;
          // Memory strobes are registered here so they appear exactly in the ISSUE cycle.
          mem_en_d   = 1'b1;
          if (grant_data) begin
            mem_addr_d  = d_addr[ADDR_W-1:2];
            mem_wdata_d = d_wdata;
            mem_we_d    = d_we ? d_wmask : 4'b0000;
          end else begin
            mem_addr_d  = if_addr[ADDR_W-1:2];
          end
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (cnt_q == CntW'(MEM_LAT - 1)) begin
          state_d = StResp;
          if (own_data_q) begin
            d_rdata_d = we_q ? '0 : mem_rdata;
            d_rsp_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_rsp_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      own_data_q  <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rsp_q    <= 1'b0;
      d_rsp_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_data_q  <= own_data_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rsp_q    <= if_rsp_d;
      d_rsp_q     <= d_rsp_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign if_rsp_valid = if_rsp_q;
  assign d_rsp_valid  = d_rsp_q;
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign busy         = ~idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction model.
// A second instance runs with MEM_LAT=3 to cover the longer latency.
module tb_mem_port_arbiter;
  localparam int unsigned LAT = 1;
`ifdef ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_req_valid, if_req_ready, if_rsp_valid, d_req_valid, d_req_ready, d_we;
  logic        d_rsp_valid, mem_en, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0]  d_wmask, mem_we;
  logic [29:0] mem_addr;

  logic        if_req_valid3, if_req_ready3, if_rsp_valid3, d_req_valid3, d_req_ready3, d_we3;
  logic        d_rsp_valid3, mem_en3, busy3;
  logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [3:0]  d_wmask3, mem_we3;
  logic [29:0] mem_addr3;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr), .d_we(d_we),
    .d_wmask(d_wmask), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid3), .if_req_ready(if_req_ready3), .if_addr(if_addr3),
    .if_rsp_valid(if_rsp_valid3), .if_rdata(if_rdata3),
    .d_req_valid(d_req_valid3), .d_req_ready(d_req_ready3), .d_addr(d_addr3), .d_we(d_we3),
    .d_wmask(d_wmask3), .d_wdata(d_wdata3), .d_rsp_valid(d_rsp_valid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  int checks = 0;
  int errors = 0;
  bit last_d = 1'b0;
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_if_rd, exp_d_rd;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : 32'(32'h9E37_79B9 * (i + 1));
  endfunction

  // Arbitration rule: data wins unless round-robin says fetch is owed a turn.
  function automatic bit model_data_wins(input bit dv, input bit fv, input bit ld);
    return dv && (!fv || !RrEn || !ld);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  // Memory environment for the MEM_LAT=1 instance; junk outside the valid read cycle.
  logic [31:0] env_mem [0:63];
  logic        mem_loaded = 1'b0;
  logic        rd_vld = 1'b0;
  logic [31:0] rd_data, junk;
  always @(posedge clk) begin
    junk   <= $urandom;
    rd_vld <= mem_en;
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      rd_data <= env_mem[mem_addr[5:0]];
      env_mem[mem_addr[5:0]] <= merge(env_mem[mem_addr[5:0]], mem_wdata, mem_we);
    end
  end
  assign mem_rdata = rd_vld ? rd_data : junk;

  // MEM_LAT=3 environment: returns an address-derived pattern three cycles after mem_en.
  logic [2:0]  v3 = 3'b000;
  logic [31:0] p0, p1, p2;
  always @(posedge clk) begin
    v3 <= {v3[1:0], mem_en3};
    p0 <= 32'hA500_0000 ^ {2'b00, mem_addr3};
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata3 = v3[2] ? p2 : junk;

  assert property (@(posedge clk) disable iff (!rst_n)
                   (d_req_valid && !d_req_ready) |=> d_req_valid)
    else $error("protocol violation: d_req_valid dropped before accept");
  assert property (@(posedge clk) disable iff (!rst_n)
                   (if_req_valid && !if_req_ready) |=> if_req_valid)
    else $error("protocol violation: if_req_valid dropped before accept");

  task automatic test_reset();
    #2;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 67'b0) begin
      errors++; $display("FAIL reset_mem got=%h exp=0", {mem_en, mem_we, mem_addr, mem_wdata});
    end
    checks++;
    if ({if_rsp_valid, d_rsp_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ctl got=%b exp=000", {if_rsp_valid, d_rsp_valid, busy});
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'b0) begin
      errors++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, d_rdata});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({if_req_ready, d_req_ready, busy, mem_en} !== 4'b0000) begin
      errors++; $display("FAIL idle_after_reset got=%b exp=0000",
                         {if_req_ready, d_req_ready, busy, mem_en});
    end
  endtask

  task automatic test_fetch();
    if_req_valid = 1'b1; if_addr = 32'h0000_0010; #1;
    checks++;
    if ({if_req_ready, d_req_ready} !== 2'b10) begin
      errors++; $display("FAIL fetch_ready got=%b exp=10", {if_req_ready, d_req_ready});
    end
    last_d = 1'b0;
    @(negedge clk); if_req_valid = 1'b0; #1;
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'b0000, 30'h4}) begin
      errors++; $display("FAIL fetch_issue got=%h exp=%h", {mem_en, mem_we, mem_addr},
                         {1'b1, 4'b0000, 30'h4});
    end
    @(negedge clk); #1;
    checks++;
    if ({mem_en, if_rsp_valid, busy} !== 3'b001) begin
      errors++; $display("FAIL fetch_wait got=%b exp=001", {mem_en, if_rsp_valid, busy});
    end
    @(negedge clk); #1;
    checks++;
    if ({if_rsp_valid, d_rsp_valid, if_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL fetch_rsp got=%b/%b/%h exp=1/0/deadbeef",
                         if_rsp_valid, d_rsp_valid, if_rdata);
    end
    @(negedge clk); #1;
    checks++;
    if ({if_rsp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL fetch_end got=%b exp=00", {if_rsp_valid, busy});
    end
  endtask

  task automatic test_store();
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wmask = 4'b0011;
    d_wdata = 32'h1234_5678; #1;
    checks++;
    if ({d_req_ready, if_req_ready} !== 2'b10) begin
      errors++; $display("FAIL store_ready got=%b exp=10", {d_req_ready, if_req_ready});
    end
    ref_mem[8] = merge(ref_mem[8], 32'h1234_5678, 4'b0011);
    last_d = 1'b1;
    @(negedge clk); d_req_valid = 1'b0; #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 30'h8, 32'h1234_5678}) begin
      errors++; $display("FAIL store_issue got=%h exp=%h", {mem_en, mem_we, mem_addr, mem_wdata},
                         {1'b1, 4'b0011, 30'h8, 32'h1234_5678});
    end
    @(negedge clk); #1;
    checks++;
    if ({mem_en, mem_we} !== 5'b0) begin
      errors++; $display("FAIL store_we_once got=%b exp=00000", {mem_en, mem_we});
    end
    @(negedge clk); #1;
    checks++;
    if ({d_rsp_valid, if_rsp_valid, d_rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL store_rsp got=%b/%b/%h exp=1/0/0", d_rsp_valid, if_rsp_valid, d_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit win_d;
    int loser_acc;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h40; if_req_valid = 1'b1; if_addr = 32'h44; #1;
    win_d = model_data_wins(1'b1, 1'b1, last_d);
    checks++;
    if ({d_req_ready, if_req_ready} !== {win_d, !win_d}) begin
      errors++; $display("FAIL contend_ready got=%b exp=%b", {d_req_ready, if_req_ready},
                         {win_d, !win_d});
    end
    loser_acc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin if (win_d) d_req_valid = 1'b0; else if_req_valid = 1'b0; end
      if (loser_acc != 0 && i == loser_acc + 1) begin
        if (win_d) if_req_valid = 1'b0; else d_req_valid = 1'b0;
      end
      #1;
      if (loser_acc == 0 && (win_d ? if_req_ready : d_req_ready)) loser_acc = i;
      if (i == 3) begin
        checks++;
        if ({d_rsp_valid, if_rsp_valid} !== {win_d, !win_d} ||
            (win_d ? d_rdata : if_rdata) !== ref_mem[win_d ? 16 : 17]) begin
          errors++; $display("FAIL contend_first_rsp got=%b/%h exp=%b/%h",
                             {d_rsp_valid, if_rsp_valid}, win_d ? d_rdata : if_rdata,
                             {win_d, !win_d}, ref_mem[win_d ? 16 : 17]);
        end
      end
      if (i == 7) begin
        checks++;
        if ({d_rsp_valid, if_rsp_valid} !== {!win_d, win_d} ||
            (win_d ? if_rdata : d_rdata) !== ref_mem[win_d ? 17 : 16]) begin
          errors++; $display("FAIL contend_second_rsp got=%b/%h exp=%b/%h",
                             {d_rsp_valid, if_rsp_valid}, win_d ? if_rdata : d_rdata,
                             {!win_d, win_d}, ref_mem[win_d ? 17 : 16]);
        end
      end
    end
    checks++;
    if (loser_acc != 4) begin
      errors++; $display("FAIL contend_gap got=%0d exp=4", loser_acc);
    end
    last_d = !win_d;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    bit dv, fv, exp_d;
    int n_acc;
    dv = 1'b1; fv = 1'b1;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h60; if_req_valid = 1'b1; if_addr = 32'h64;
    n_acc = 0;
    for (int i = 0; i < 60 && n_acc < 5; i++) begin
      #1;
      if (d_req_ready || if_req_ready) begin
        exp_d = model_data_wins(dv, fv, last_d);
        checks++;
        if ({d_req_ready, if_req_ready} !== {exp_d, !exp_d}) begin
          errors++; $display("FAIL arb_grant%0d got=%b exp=%b", n_acc,
                             {d_req_ready, if_req_ready}, {exp_d, !exp_d});
        end
        last_d = exp_d;
        n_acc++;
        @(negedge clk);
        if (n_acc >= 4) begin
          if (exp_d) dv = 1'b0; else fv = 1'b0;
          d_req_valid = dv; if_req_valid = fv;
        end
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (n_acc != 5) begin
      errors++; $display("FAIL arb_count got=%0d exp=5", n_acc);
    end
    d_req_valid = 1'b0; if_req_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int stray;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    @(negedge clk); d_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; #1;
    checks++;
    if ({busy, mem_en, mem_we, mem_addr, mem_wdata, if_rsp_valid, d_rsp_valid} !== 70'b0) begin
      errors++; $display("FAIL rst_mid_outputs busy=%b mem_en=%b exp=0", busy, mem_en);
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'b0) begin
      errors++; $display("FAIL rst_mid_rdata got=%h exp=0", {if_rdata, d_rdata});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    last_d = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (if_rsp_valid || d_rsp_valid || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL rst_mid_stray got=%0d exp=0", stray);
    end
    if_req_valid = 1'b1; if_addr = 32'h26; #1;
    checks++;
    if (if_req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready got=%b exp=1", if_req_ready);
    end
    @(negedge clk); if_req_valid = 1'b0; #1;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 30'h9}) begin
      errors++; $display("FAIL rst_mid_issue got=%h exp=%h", {mem_en, mem_addr}, {1'b1, 30'h9});
    end
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({if_rsp_valid, if_rdata} !== {1'b1, ref_mem[9]}) begin
      errors++; $display("FAIL rst_mid_rsp got=%b/%h exp=1/%h", if_rsp_valid, if_rdata, ref_mem[9]);
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    bit p_if, p_d, win_d, dwe;
    logic [31:0] a_if, a_d, wd, exp_rsp;
    logic [3:0] msk;
    int idx;
    rst_n = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_if_rd = '0; exp_d_rd = '0; last_d = 1'b0;
    p_if = 1'b0; p_d = 1'b0; a_if = '0; a_d = '0; dwe = 1'b0; msk = '0; wd = '0;
    for (int t = 0; t < n || p_if || p_d; t++) begin
      if (t < n && !p_if && $urandom_range(0, 2) != 0) begin
        p_if = 1'b1; a_if = $urandom_range(0, 255);
      end
      if (t < n && !p_d && $urandom_range(0, 2) != 0) begin
        p_d = 1'b1; a_d = $urandom_range(0, 255); dwe = 1'($urandom_range(0, 1));
        msk = 4'($urandom_range(0, 15)); wd = $urandom;
      end
      if_req_valid = p_if; if_addr = a_if;
      d_req_valid = p_d; d_addr = a_d; d_we = dwe; d_wmask = msk; d_wdata = wd;
      #1;
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL rand_idle_busy got=%b exp=0", busy);
      end
      if (!p_if && !p_d) begin
        @(negedge clk);
        continue;
      end
      win_d = model_data_wins(p_d, p_if, last_d);
      checks++;
      if ({d_req_ready, if_req_ready} !== {win_d, !win_d}) begin
        errors++; $display("FAIL rand_ready got=%b exp=%b", {d_req_ready, if_req_ready},
                           {win_d, !win_d});
      end
      idx = win_d ? int'(a_d[7:2]) : int'(a_if[7:2]);
      exp_rsp = (win_d && dwe) ? 32'h0 : ref_mem[idx];
      if (win_d && dwe) ref_mem[idx] = merge(ref_mem[idx], wd, msk);
      last_d = win_d;
      @(negedge clk);
      if (win_d) begin p_d = 1'b0; d_req_valid = 1'b0; end
      else begin p_if = 1'b0; if_req_valid = 1'b0; end
      if (t < n && win_d && !p_if && $urandom_range(0, 1) == 1) begin
        p_if = 1'b1; a_if = $urandom_range(0, 255); if_req_valid = 1'b1; if_addr = a_if;
      end else if (t < n && !win_d && !p_d && $urandom_range(0, 1) == 1) begin
        p_d = 1'b1; a_d = $urandom_range(0, 255); dwe = 1'($urandom_range(0, 1));
        msk = 4'($urandom_range(0, 15)); wd = $urandom;
        d_req_valid = 1'b1; d_addr = a_d; d_we = dwe; d_wmask = msk; d_wdata = wd;
      end
      #1;
      checks++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, (win_d && dwe) ? msk : 4'b0000, 30'(idx)} ||
          (win_d && dwe && mem_wdata !== wd)) begin
        errors++; $display("FAIL rand_issue got=%b/%b/%h/%h exp=1/%b/%h/%h", mem_en, mem_we,
                           mem_addr, mem_wdata, (win_d && dwe) ? msk : 4'b0000, 30'(idx), wd);
      end
      for (int i = 2; i <= 2 + int'(LAT); i++) begin
        @(negedge clk); #1;
        if (i == 2 + int'(LAT)) begin
          if (win_d) exp_d_rd = exp_rsp; else exp_if_rd = exp_rsp;
        end
        checks++;
        if ({mem_en, mem_we, if_req_ready, d_req_ready, busy} !== 8'b0000_0001) begin
          errors++; $display("FAIL rand_busy got=%b exp=00000001",
                             {mem_en, mem_we, if_req_ready, d_req_ready, busy});
        end
        checks++;
        if ({d_rsp_valid, if_rsp_valid} !== ((i == 2 + int'(LAT)) ? {win_d, !win_d} : 2'b00)) begin
          errors++; $display("FAIL rand_rsp_valid cyc=%0d got=%b", i, {d_rsp_valid, if_rsp_valid});
        end
        checks++;
        if ({if_rdata, d_rdata} !== {exp_if_rd, exp_d_rd}) begin
          errors++; $display("FAIL rand_rdata got=%h/%h exp=%h/%h", if_rdata, d_rdata,
                             exp_if_rd, exp_d_rd);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lat3();
    logic [31:0] a, exp;
    int rsp_at, busy_cnt, if_pulses;
    for (int k = 0; k < 3; k++) begin
      a = $urandom;
      exp = 32'hA500_0000 ^ {2'b00, a[31:2]};
      @(negedge clk);
      d_req_valid3 = 1'b1; d_addr3 = a; d_we3 = 1'b0; #1;
      checks++;
      if (d_req_ready3 !== 1'b1) begin
        errors++; $display("FAIL lat3_ready got=%b exp=1", d_req_ready3);
      end
      rsp_at = 0; busy_cnt = 0; if_pulses = 0;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (i == 1) d_req_valid3 = 1'b0;
        #1;
        if (busy3) busy_cnt++;
        if (if_rsp_valid3) if_pulses++;
        if (i == 1) begin
          checks++;
          if ({mem_en3, mem_addr3} !== {1'b1, a[31:2]}) begin
            errors++; $display("FAIL lat3_issue got=%h exp=%h", {mem_en3, mem_addr3}, {1'b1, a[31:2]});
          end
        end
        if (d_rsp_valid3) begin
          if (rsp_at == 0) rsp_at = i;
          checks++;
          if (d_rdata3 !== exp) begin
            errors++; $display("FAIL lat3_rdata got=%h exp=%h", d_rdata3, exp);
          end
        end
      end
      checks++;
      if (rsp_at != 5) begin
        errors++; $display("FAIL lat3_latency got=%0d exp=5", rsp_at);
      end
      checks++;
      if (busy_cnt != 5 || if_pulses != 0) begin
        errors++; $display("FAIL lat3_busy got=%0d/%0d exp=5/0", busy_cnt, if_pulses);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    if_req_valid = 1'b0; if_addr = '0; d_req_valid = 1'b0; d_addr = '0; d_we = 1'b0;
    d_wmask = '0; d_wdata = '0;
    if_req_valid3 = 1'b0; if_addr3 = '0; d_req_valid3 = 1'b0; d_addr3 = '0; d_we3 = 1'b0;
    d_wmask3 = '0; d_wdata3 = '0;
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_arbitration();
    test_reset_mid();
    test_random(150);
    test_lat3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
